adder_result_fifo: RTL and testbench

- Downstream capture stage for the registered ripple-carry adder; sits directly after it.
- Re-aligns the adder's combinational carry with its one-cycle-registered sum.
- Stores {carry, sum} results in a small synchronous FIFO and presents them on a valid/ready interface.
- The adder cannot be stalled, so results arriving while the FIFO is full are dropped and flagged.

---
 rtl/adder_fifo_pkg.sv | 12 +
 rtl/adder_fifo_mem.sv | 26 ++
 rtl/adder_result_fifo.sv | 96 +++++++++
 tb/tb_adder_result_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adder_fifo_pkg.sv
// Shared constants and helpers for the adder result FIFO.
package adder_fifo_pkg;

  localparam int        DROP_CNT_W   = 8;
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  // Occupancy counter width: needs to represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adder_fifo_mem.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read
// port. Contents are not reset; the top never reads an unwritten slot while
// out_valid_o is high.
module adder_fifo_mem #(
  parameter  int W     = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// Capture stage behind the registered ripple-carry adder. The adder's carry is
// combinational while its sum is registered, so the carry and valid are delayed
// one cycle to line up with the sum before {carry, sum} is pushed into a small
// first-word-fall-through FIFO. The adder cannot stall: a result arriving while
// the FIFO is full (and not being popped) is dropped and overflow_o latches.
// Optional: ADDER_FIFO_DROP_CNT_EN adds a saturating 8-bit drop counter output.
// Optional: USE_POWER_PINS adds VPWR/VGND.
module adder_result_fifo import adder_fifo_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                          VPWR,
  inout  wire                          VGND,
`endif
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic                         carry_i,
  input  logic [WIDTH-1:0]             sum_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_sum_o,
  output logic                         out_carry_o,
  output logic [level_w(DEPTH)-1:0]    level_o,
  output logic                         overflow_o
`ifdef ADDER_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_count_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = WIDTH + 1;
  localparam int LW = level_w(DEPTH);

  logic          s1_valid, s1_carry;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          full, pop, push, drop;

  assign full     = (level_o == LW'(DEPTH));
  assign pop      = out_valid_o && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = s1_valid && (!full || pop);
  assign drop     = s1_valid && full && !pop;
  assign wr_entry = {s1_carry, sum_i};

  // Delay carry/valid one cycle so they describe the same addition as sum_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_carry <= 1'b0;
    end else begin
      s1_valid <= in_valid_i;
      s1_carry <= carry_i;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level_o <= level_o + LW'(1);
      else if (pop && !push) level_o <= level_o - LW'(1);
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef ADDER_FIFO_DROP_CNT_EN
  // Count dropped results, saturating at the top of the range.
  always_ff @(posedge clk) begin
    if (rst)                                    drop_count_o <= '0;
    else if (drop && drop_count_o != DROP_CNT_MAX) drop_count_o <= drop_count_o + 1'b1;
  end
`endif

  adder_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign out_valid_o = (level_o != '0);
  assign {out_carry_o, out_sum_o} = out_valid_o ? rd_entry : '0;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo (WIDTH=4, DEPTH=4). The upstream adder is
// modelled by cyc(): carry/valid are applied with the operands, the sum shows
// up one cycle later.
module tb_adder_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_i, carry_i, out_ready_i;
  logic [3:0] sum_i;
  logic       out_valid_o, out_carry_o, overflow_o;
  logic [3:0] out_sum_o;
  logic [2:0] level_o;
`ifdef ADDER_FIFO_DROP_CNT_EN
  logic [7:0] drop_count_o;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] pend_sum = '0;

  adder_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .carry_i     (carry_i),
    .sum_i       (sum_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sum_o   (out_sum_o),
    .out_carry_o (out_carry_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
`ifdef ADDER_FIFO_DROP_CNT_EN
    ,
    .drop_count_o(drop_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One adder cycle: res = {carry, sum} of the operands applied now.
  task automatic cyc(input logic v, input logic [4:0] res, input logic rdy);
    in_valid_i  = v;
    carry_i     = res[4];
    sum_i       = pend_sum;
    pend_sum    = res[3:0];
    out_ready_i = rdy;
    @(posedge clk); #1;
  endtask

  // One reset cycle; v lets a result be offered during reset.
  task automatic do_rst(input logic v);
    rst        = 1'b1;
    in_valid_i = v;
    carry_i    = 1'b1;
    sum_i      = pend_sum;
    pend_sum   = '0;
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [4:0] exp);
    chk({tag, "_vld"}, out_valid_o, 1'b1);
    chk(tag, {out_carry_o, out_sum_o}, exp);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_vld"}, out_valid_o, 1'b0);
    chk({tag, "_dat"}, {out_carry_o, out_sum_o}, 5'h00);
    chk({tag, "_lvl"}, level_o, 3'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; carry_i = 1'b0; sum_i = '0; out_ready_i = 1'b0;
    @(posedge clk); do_rst(1'b0);
    chk_empty("rst");
    chk("rst_ovf", overflow_o, 1'b0);
`ifdef ADDER_FIFO_DROP_CNT_EN
    chk("rst_dcnt", drop_count_o, 8'd0);
`endif

    // Basic ordering: 3+5 = 0_1000, 9+8 = 1_0001.
    cyc(1'b1, 5'(3 + 5), 1'b1);
    chk("lat_t1", out_valid_o, 1'b0);
    cyc(1'b1, 5'(9 + 8), 1'b1);
    chk_head("ord0", 5'h08);
    cyc(1'b0, 5'h00, 1'b1);
    chk_head("ord1", 5'h11);
    cyc(1'b0, 5'h00, 1'b1);
    chk_empty("ord_end");

    // Fill and drop: five results into four slots.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 5'(i), 1'b0);
    cyc(1'b0, 5'h00, 1'b0);
    chk("fill_lvl", level_o, 3'd4);
    chk("fill_ovf", overflow_o, 1'b1);
    chk_head("hold0", 5'h01);
    cyc(1'b0, 5'h00, 1'b0);
    chk_head("hold1", 5'h01);
    for (int i = 1; i <= 4; i++) begin
      chk_head("drain", 5'(i));
      cyc(1'b0, 5'h00, 1'b1);
    end
    chk_empty("drain_end");
    chk("ovf_sticky", overflow_o, 1'b1);

    // Full with simultaneous push and pop.
    do_rst(1'b0);
    chk("rst2_ovf", overflow_o, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i), 1'b0);
    cyc(1'b1, 5'h06, 1'b0);
    chk("pp_lvl0", level_o, 3'd4);
    cyc(1'b0, 5'h00, 1'b1);
    chk("pp_lvl1", level_o, 3'd4);
    chk("pp_ovf", overflow_o, 1'b0);
    chk_head("pp0", 5'h02);
    cyc(1'b0, 5'h00, 1'b1);
    chk_head("pp1", 5'h03);
    cyc(1'b0, 5'h00, 1'b1);
    chk_head("pp2", 5'h04);
    cyc(1'b0, 5'h00, 1'b1);
    chk_head("pp3", 5'h06);
    cyc(1'b0, 5'h00, 1'b1);
    chk_empty("pp_end");

    // Streaming: 16 results, entry j visible in the cycle after call j+1.
    for (int k = 0; k < 20; k++) begin
      cyc(k < 16, {1'(k & 1), 4'(k)}, 1'b1);
      if (k >= 1 && k <= 16) chk_head("strm", {1'((k - 1) & 1), 4'(k - 1)});
      else                   chk("strm_vld", out_valid_o, 1'b0);
      chk("strm_lvl", level_o <= 3'd1, 1'b1);
    end

    // Reset mid-stream: three stored, one in the alignment stage.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(8 + i), 1'b0);
    chk("pre_lvl", level_o, 3'd3);
    do_rst(1'b1);
    chk_empty("mrst");
    chk("mrst_ovf", overflow_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'h00, 1'b1);
      chk_empty("mrst_idle");
    end

`ifdef ADDER_FIFO_DROP_CNT_EN
    // 4 fill the FIFO, the next 300 are dropped; counter saturates.
    for (int i = 0; i < 304; i++) cyc(1'b1, 5'(i), 1'b0);
    cyc(1'b0, 5'h00, 1'b0);
    chk("dcnt_sat", drop_count_o, 8'd255);
    chk("dcnt_lvl", level_o, 3'd4);
    do_rst(1'b0);
    chk("dcnt_rst", drop_count_o, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
